// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU ops, mult/div ops, result and forward selects, md FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_NONE7 = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_HI   = 2'b01,
    RS_LO   = 2'b10,
    RS_ALU3 = 2'b11
  } res_sel_t;

  typedef enum logic [1:0] {
    FW_REG  = 2'b00,
    FW_WB   = 2'b01,
    FW_MEM  = 2'b10,
    FW_REG3 = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  // Per-operation control captured at the accepting edge.
  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_hi;
    logic dz;
  } md_ctl_t;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative mult/div with HI/LO: WIDTH step cycles plus one sign-fix cycle, busy WIDTH+1 cycles;
// MTHI/MTLO write in one edge. New ops are taken only in IDLE with hold low; no internal bypass.
module md_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       mdop,
  input  logic             hold,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, acc_hi, acc_lo, opd;
  md_ctl_t          ctl;

  logic             accept, arith, sgn, is_div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept    = (state == MD_IDLE) && !hold;
  assign arith     = md_is_arith(mdop);
  assign sgn       = (mdop == MD_MULT) || (mdop == MD_DIV);
  assign is_div_op = (mdop == MD_DIV) || (mdop == MD_DIVU);
  assign a_neg     = sgn & srca[WIDTH-1];
  assign b_neg     = sgn & srcb[WIDTH-1];
  assign a_mag     = a_neg ? -srca : srca;
  assign b_mag     = b_neg ? -srcb : srcb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (accept && arith) state_nx = MD_RUN;
      MD_RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH+1:0] div_tr;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             unused_tr;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_tr    = {1'b0, div_sh} - {2'b00, opd};
  assign unused_tr = div_tr[WIDTH];

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (ctl.is_div) begin
      if (!div_tr[WIDTH+1]) begin
        step_hi = div_tr[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction; with a zero divisor the remainder path already holds |dividend|.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = ctl.neg_lo ? -prod : prod;
  assign q_fix    = ctl.dz ? '1 : (ctl.neg_lo ? -acc_lo : acc_lo);
  assign r_fix    = ctl.neg_hi ? -acc_hi : acc_hi;
  assign fix_hi   = ctl.is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = ctl.is_div ? q_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      ctl    <= '0;
    end else begin
      case (state)
        MD_IDLE: if (accept) begin
          if (mdop == MD_MTHI) hi_q <= srca;
          if (mdop == MD_MTLO) lo_q <= srca;
          if (arith) begin
            cnt    <= '0;
            ctl    <= '{is_div_op, a_neg ^ b_neg, a_neg, is_div_op && (srcb == '0)};
            acc_hi <= '0;
            acc_lo <= is_div_op ? a_mag : b_mag;
            opd    <= is_div_op ? b_mag : a_mag;
          end
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
        MD_FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state != MD_IDLE);

endmodule

// File: rtl/execute_stage_md.sv
// MIPS execute stage: operand forwarding, ALU and HI/LO result select, all combinational;
// mult/div busy WIDTH+1 cycles, stall requested while busy if the E instruction needs the unit.
module execute_stage_md
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [RW-1:0]    RsE,
  input  logic [RW-1:0]    RtE,
  input  logic [RW-1:0]    RdE,
  input  logic [WIDTH-1:0] SignImmE,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic             RegDstE,
  input  logic             ALUSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [2:0]       MDOpE,
  input  logic [1:0]       ResultSelE,
  input  logic             HoldE,
  output logic [WIDTH-1:0] ALUOutE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [RW-1:0]    WriteRegE,
  output logic [RW-1:0]    RsE_HZ,
  output logic [RW-1:0]    RtE_HZ,
  output logic             MDBusyE,
  output logic             MDStallE
);

  logic [WIDTH-1:0] srca, srcb, alu_y, hi, lo;

  always_comb begin
    case (ForwardAE)
      FW_WB:   srca = ResultW;
      FW_MEM:  srca = ALUOutM;
      default: srca = RD1E;
    endcase
    case (ForwardBE)
      FW_WB:   WriteDataE = ResultW;
      FW_MEM:  WriteDataE = ALUOutM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign srcb      = ALUSrcE ? SignImmE : WriteDataE;
  assign WriteRegE = RegDstE ? RdE : RtE;
  assign RsE_HZ    = RsE;
  assign RtE_HZ    = RtE;

  // Unlisted ALU codes fall through to OR.
  always_comb begin
    alu_y = srca | srcb;
    case (ALUControlE)
      ALU_AND: alu_y = srca & srcb;
      ALU_ADD: alu_y = srca + srcb;
      ALU_SUB: alu_y = srca - srcb;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: ;
    endcase
  end

  always_comb begin
    case (ResultSelE)
      RS_HI:   ALUOutE = hi;
      RS_LO:   ALUOutE = lo;
      default: ALUOutE = alu_y;
    endcase
  end

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk  (clk),
    .rst  (rst),
    .srca (srca),
    .srcb (srcb),
    .mdop (MDOpE),
    .hold (HoldE),
    .hi   (hi),
    .lo   (lo),
    .busy (MDBusyE)
  );

  assign MDStallE = MDBusyE & (((MDOpE != MD_NONE) && (MDOpE != MD_NONE7)) ||
                               (ResultSelE == RS_HI) || (ResultSelE == RS_LO));

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;

  logic        clk, rst;
  logic [31:0] RD1E, RD2E, SignImmE, ALUOutM, ResultW;
  logic [4:0]  RsE, RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE, ResultSelE;
  logic        RegDstE, ALUSrcE, HoldE;
  logic [2:0]  ALUControlE, MDOpE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE, RsE_HZ, RtE_HZ;
  logic        MDBusyE, MDStallE;

  execute_stage_md #(.WIDTH(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .SignImmE(SignImmE), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .MDOpE(MDOpE), .ResultSelE(ResultSelE), .HoldE(HoldE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RsE_HZ(RsE_HZ), .RtE_HZ(RtE_HZ), .MDBusyE(MDBusyE), .MDStallE(MDStallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd1, rd2, imm, aluoutm, resultw;
    logic [1:0]  fa, fb, rsel;
    logic        alusrc, regdst;
    logic [2:0]  ctl;
    logic [4:0]  rt, rd;
    logic [31:0] e_out, e_wd;
    logic [4:0]  e_wr;
  } cvec_t;

  cvec_t tbl[11];

  function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [2:0] c);
    case (c)
      3'd0:    return a & b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [31:0] fwd_model(input logic [1:0] s, input logic [31:0] r, w, m);
    return (s == 2'd1) ? w : (s == 2'd2) ? m : r;
  endfunction

  // HI/LO architectural effect of one op, from plain integer arithmetic.
  task automatic md_model(input logic [2:0] op, input logic [31:0] a, b,
                          output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    eh = m_hi;
    el = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'd2: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      3'd3: if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
            else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      3'd4: if (b == 0) begin el = 32'hFFFFFFFF; eh = a; end
            else begin el = a / b; eh = a % b; end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, b, input string nm,
                        input bit use_exp, input logic [31:0] xh, xl);
    int cyc;
    logic [31:0] eh, el;
    md_model(op, a, b, eh, el);
    if (use_exp) begin eh = xh; el = xl; end
    ForwardAE = 2'd0; ForwardBE = 2'd0; ALUSrcE = 1'b0; HoldE = 1'b0; ResultSelE = 2'd0;
    RD1E = a; RD2E = b; MDOpE = op;
    @(posedge clk); #1;
    MDOpE = 3'd0; RD1E = $urandom; RD2E = $urandom;
    cyc = 0;
    @(negedge clk);
    while (MDBusyE && cyc < 100) begin cyc++; @(negedge clk); end
    chk({nm, " busy_cycles"}, 64'(cyc), (op >= 3'd1 && op <= 3'd4) ? 64'd33 : 64'd0);
    ResultSelE = 2'd1; #1 chk({nm, " hi"}, {32'h0, ALUOutE}, {32'h0, eh});
    ResultSelE = 2'd2; #1 chk({nm, " lo"}, {32'h0, ALUOutE}, {32'h0, el});
    ResultSelE = 2'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] eh, el, a, b, wd;
    logic [2:0]  op;
    int cyc;

    rst = 1'b1; RD1E = 0; RD2E = 0; SignImmE = 0; ALUOutM = 0; ResultW = 0;
    RsE = 0; RtE = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultSelE = 0;
    RegDstE = 0; ALUSrcE = 0; HoldE = 0; ALUControlE = 0; MDOpE = 0;

    #2;
    chk("reset busy", {63'h0, MDBusyE}, 64'd0);
    chk("reset stall", {63'h0, MDStallE}, 64'd0);
    ResultSelE = 2'd1; #1 chk("reset hi", {32'h0, ALUOutE}, 64'd0);
    ResultSelE = 2'd2; #1 chk("reset lo", {32'h0, ALUOutE}, 64'd0);
    ResultSelE = 2'd0;
    @(negedge clk); rst = 1'b0;

    //           rd1           rd2           imm        aluoutm   resultw  fa    fb    rsel  src   dst   ctl   rt     rd      out           wd            wr
    tbl[0]  = '{32'h5,        32'h99,       32'h1,     32'h12,   32'h0,   2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 3'd2, 5'd3,  5'd9,  32'h13,       32'h99,       5'd3};
    tbl[1]  = '{32'h55,       32'h66,       32'h0,     32'h3,    32'd10,  2'd1, 2'd2, 2'd0, 1'b0, 1'b1, 3'd6, 5'd4,  5'd17, 32'h7,        32'h3,        5'd17};
    tbl[2]  = '{32'hFFFFFFFF, 32'h1,        32'h0,     32'h0,    32'h0,   2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 3'd7, 5'd1,  5'd2,  32'h1,        32'h1,        5'd1};
    tbl[3]  = '{32'h5,        32'h80000000, 32'h0,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd7, 5'd31, 5'd0,  32'h0,        32'h80000000, 5'd31};
    tbl[4]  = '{32'hF0F0,     32'h0,        32'hFF00,  32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 5'd0,  5'd5,  32'hF000,     32'h0,        5'd5};
    tbl[5]  = '{32'hF0,       32'h0F,       32'h0,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 5'd6,  5'd7,  32'hFF,       32'h0F,       5'd6};
    tbl[6]  = '{32'h100,      32'h1,        32'h0,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd3, 5'd8,  5'd9,  32'h101,      32'h1,        5'd8};
    tbl[7]  = '{32'hFFFFFFFF, 32'h0,        32'h2,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd2, 5'd10, 5'd11, 32'h1,        32'h0,        5'd10};
    tbl[8]  = '{32'h4,        32'h8,        32'h0,     32'd77,   32'd99,  2'd3, 2'd1, 2'd3, 1'b0, 1'b0, 3'd2, 5'd12, 5'd13, 32'h67,       32'h63,       5'd12};
    tbl[9]  = '{32'h1,        32'h2,        32'h0,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd6, 5'd14, 5'd15, 32'hFFFFFFFF, 32'h2,        5'd14};
    tbl[10] = '{32'hA,        32'h5,        32'h0,     32'h0,    32'h0,   2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd5, 5'd16, 5'd18, 32'hF,        32'h5,        5'd16};

    for (int i = 0; i < 11; i++) begin
      RD1E = tbl[i].rd1; RD2E = tbl[i].rd2; SignImmE = tbl[i].imm;
      ALUOutM = tbl[i].aluoutm; ResultW = tbl[i].resultw;
      ForwardAE = tbl[i].fa; ForwardBE = tbl[i].fb; ResultSelE = tbl[i].rsel;
      ALUSrcE = tbl[i].alusrc; RegDstE = tbl[i].regdst; ALUControlE = tbl[i].ctl;
      RtE = tbl[i].rt; RdE = tbl[i].rd; RsE = 5'(i);
      #1;
      chk($sformatf("vec%0d aluout", i), {32'h0, ALUOutE}, {32'h0, tbl[i].e_out});
      chk($sformatf("vec%0d wdata", i), {32'h0, WriteDataE}, {32'h0, tbl[i].e_wd});
      chk($sformatf("vec%0d wreg", i), {59'h0, WriteRegE}, {59'h0, tbl[i].e_wr});
    end

    for (int i = 0; i < 25; i++) begin
      RD1E = $urandom; RD2E = $urandom; SignImmE = $urandom; ALUOutM = $urandom; ResultW = $urandom;
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ALUSrcE = 1'($urandom);
      RegDstE = 1'($urandom); ALUControlE = 3'($urandom);
      RsE = 5'($urandom); RtE = 5'($urandom); RdE = 5'($urandom);
      ResultSelE = $urandom_range(0, 1) ? 2'd3 : 2'd0;
      #1;
      wd = fwd_model(ForwardBE, RD2E, ResultW, ALUOutM);
      a  = fwd_model(ForwardAE, RD1E, ResultW, ALUOutM);
      b  = ALUSrcE ? SignImmE : wd;
      chk($sformatf("rnd%0d aluout", i), {32'h0, ALUOutE}, {32'h0, alu_model(a, b, ALUControlE)});
      chk($sformatf("rnd%0d wdata", i), {32'h0, WriteDataE}, {32'h0, wd});
      chk($sformatf("rnd%0d regs", i), {49'h0, WriteRegE, RsE_HZ, RtE_HZ},
          {49'h0, (RegDstE ? RdE : RtE), RsE, RtE});
    end
    ResultSelE = 2'd0; ALUControlE = 3'd2;
    @(negedge clk);

    run_md(3'd1, 32'hFFFFFFFD, 32'd7, "mult_m3x7", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, "div_m7d2", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md(3'd4, 32'd7, 32'd0, "divu_7d0", 1'b1, 32'h7, 32'hFFFFFFFF);
    run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_min_m1", 1'b0, 32'h0, 32'h0);
    run_md(3'd3, 32'hFFFFFFF0, 32'd0, "div_neg_d0", 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = -a;
      run_md(op, a, b, $sformatf("md_rnd%0d_op%0d", i, op), 1'b0, 32'h0, 32'h0);
    end

    // MFLO two cycles behind MULT, with a non-md instruction between them.
    RD1E = 32'h1234; RD2E = 32'h10; MDOpE = 3'd1; ResultSelE = 2'd0;
    md_model(3'd1, 32'h1234, 32'h10, eh, el);
    @(posedge clk); #1;
    MDOpE = 3'd0; RD1E = 32'hDEAD; RD2E = 32'hBEEF;
    @(negedge clk);
    chk("mflo_gap stall_nop", {62'h0, MDBusyE, MDStallE}, {62'h0, 2'b10});
    @(posedge clk); #1;
    ResultSelE = 2'd2;
    cyc = 0;
    @(negedge clk);
    while (MDStallE && cyc < 100) begin cyc++; @(negedge clk); end
    chk("mflo_gap stall_cycles", 64'(cyc), 64'd32);
    chk("mflo_gap new_lo", {32'h0, ALUOutE}, {32'h0, el});
    ResultSelE = 2'd0;

    // MULT held off by the hazard unit for three edges.
    RD1E = 32'd5; RD2E = 32'd6; MDOpE = 3'd1; HoldE = 1'b1;
    md_model(3'd1, 32'd5, 32'd6, eh, el);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d no_start", i), {63'h0, MDBusyE}, 64'd0);
    end
    HoldE = 1'b0;
    @(posedge clk); #1;
    MDOpE = 3'd0;
    cyc = 0;
    @(negedge clk);
    while (MDBusyE && cyc < 100) begin cyc++; @(negedge clk); end
    chk("hold busy_cycles", 64'(cyc), 64'd33);
    ResultSelE = 2'd2; #1 chk("hold lo", {32'h0, ALUOutE}, {32'h0, el});
    ResultSelE = 2'd0;

    // Reset in the middle of a DIVU abandons it.
    RD1E = 32'hFFFF1234; RD2E = 32'h13; MDOpE = 3'd4;
    @(posedge clk); #1;
    MDOpE = 3'd0;
    repeat (10) @(negedge clk);
    chk("rst_mid busy_before", {63'h0, MDBusyE}, 64'd1);
    #1 rst = 1'b1;
    #1 chk("rst_mid busy", {63'h0, MDBusyE}, 64'd0);
    ResultSelE = 2'd1; #1 chk("rst_mid hi", {32'h0, ALUOutE}, 64'd0);
    ResultSelE = 2'd2; #1 chk("rst_mid lo", {32'h0, ALUOutE}, 64'd0);
    ResultSelE = 2'd0;
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk); rst = 1'b0;
    run_md(3'd6, 32'hA5, 32'h0, "rst_mtlo", 1'b1, 32'h0, 32'hA5);
    repeat (40) @(negedge clk);
    chk("rst_no_resume busy", {63'h0, MDBusyE}, 64'd0);
    ResultSelE = 2'd1; #1 chk("rst_no_resume hi", {32'h0, ALUOutE}, 64'd0);
    ResultSelE = 2'd2; #1 chk("rst_no_resume lo", {32'h0, ALUOutE}, 64'h0A5);
    ResultSelE = 2'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
